// File: rtl/cmp_serial.sv
// Serial magnitude comparator: walks the operands two bits at a time, MSB slice first.
// Optional CMP_EARLY_EXIT_EN finishes at the first differing slice instead of running all slices.
module cmp_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam int HALF = WIDTH / 2;
  localparam int IW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(HALF - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [1:0]       slice_a;
  logic [1:0]       slice_b;
  logic             slice_lt;
  logic             slice_gt;
  logic             decided;
  logic             last_slice;
  logic             finish;

  // Current 2-bit slices and their relation
  always_comb begin
    a_sh       = a_reg >> {idx, 1'b0};
    b_sh       = b_reg >> {idx, 1'b0};
    slice_a    = a_sh[1:0];
    slice_b    = b_sh[1:0];
    slice_lt   = (slice_a < slice_b);
    slice_gt   = (slice_a > slice_b);
    decided    = lt | gt;
    last_slice = (idx == {IW{1'b0}});
  end

`ifdef CMP_EARLY_EXIT_EN
  // Stop at the last slice or at the first slice that differs
  assign finish = last_slice | (~decided & (slice_lt | slice_gt));
`else
  // Constant latency: always walk every slice
  assign finish = last_slice;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = start ? RUN : IDLE;
      RUN:     state_next = finish ? IDLE : RUN;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state == RUN);
  end

  // Operand latch, slice walk and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= {WIDTH{1'b0}};
      b_reg <= {WIDTH{1'b0}};
      idx   <= {IW{1'b0}};
      done  <= 1'b0;
      eq    <= 1'b0;
      lt    <= 1'b0;
      gt    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            idx   <= IDX_TOP;
            eq    <= 1'b0;
            lt    <= 1'b0;
            gt    <= 1'b0;
          end
        end
        RUN: begin
          // First difference wins; later slices leave the result alone
          if (!decided) begin
            if (slice_gt) begin
              gt <= 1'b1;
            end else if (slice_lt) begin
              lt <= 1'b1;
            end else if (last_slice) begin
              eq <= 1'b1;
            end
          end
          if (finish) begin
            done <= 1'b1;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_serial.sv
// Self-checking bench for cmp_serial (WIDTH=8) using an expected-result scoreboard.
// Expected latencies follow CMP_EARLY_EXIT_EN when the bench is built with it.
module tb_cmp_serial;

  localparam logic [2:0] R_EQ = 3'b100;
  localparam logic [2:0] R_LT = 3'b010;
  localparam logic [2:0] R_GT = 3'b001;
`ifdef CMP_EARLY_EXIT_EN
  localparam int LAT_S3 = 1;
`else
  localparam int LAT_S3 = 4;
`endif

  typedef struct {
    logic [2:0] res;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       busy, done, eq, lt, gt;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  cmp_serial #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .eq(eq), .lt(lt), .gt(gt)
  );

  always #5 clk = ~clk;

  // Waits (bounded) for done; reports edges since the calling point and the flags
  task automatic wait_done(output int lat, output logic [2:0] res, output bit timeout);
    lat = 0; res = 3'b000; timeout = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c; res = {eq, lt, gt}; timeout = 1'b0;
        return;
      end
    end
  endtask

  // Drives a start pulse at a negedge; returns just after the accepting edge E0
  task automatic issue(input logic [7:0] aa, input logic [7:0] bb);
    @(negedge clk);
    start = 1'b1; a = aa; b = bb;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({busy, done, eq, lt, gt} !== 5'b00000) begin
      n_bad++; $display("FAIL reset_outputs: got %b want 00000", {busy, done, eq, lt, gt});
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_main();
    logic [7:0] ta[6] = '{8'hA5, 8'h80, 8'h00, 8'hFF, 8'h3C, 8'h5A};
    logic [7:0] tb[6] = '{8'hA5, 8'h7F, 8'h00, 8'hFF, 8'hC3, 8'h5B};
    logic [2:0] tr[6] = '{R_EQ, R_GT, R_EQ, R_EQ, R_LT, R_LT};
    int         tl[6] = '{4, LAT_S3, 4, 4, LAT_S3, 4};
    int lat; logic [2:0] res; bit to; exp_t e;
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{tr[i], tl[i]});
      issue(ta[i], tb[i]);
      n_cmp++;
      if (busy !== 1'b1) begin
        n_bad++; $display("FAIL busy_after_start[%0d]: got %b want 1", i, busy);
      end
      wait_done(lat, res, to);
      e = sb.pop_front();
      n_cmp++;
      if (to || lat != e.lat) begin
        n_bad++; $display("FAIL latency[%0d]: got %0d (timeout=%0b) want %0d", i, lat, to, e.lat);
      end
      n_cmp++;
      if (res !== e.res) begin
        n_bad++; $display("FAIL result[%0d]: got %b want %b", i, res, e.res);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({busy, done, eq, lt, gt} !== {2'b00, e.res}) begin
        n_bad++; $display("FAIL hold[%0d]: got %b want %b", i, {busy, done, eq, lt, gt}, {2'b00, e.res});
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [2:0] res; bit to; exp_t e;
    sb.push_back('{R_LT, 4});
    issue(8'h12, 8'h13);
    wait_done(lat, res, to);
    e = sb.pop_front();
    n_cmp++;
    if (to || lat != e.lat || res !== e.res) begin
      n_bad++; $display("FAIL b2b_first: got lat %0d res %b want lat %0d res %b", lat, res, e.lat, e.res);
    end
    // Start issued while done is high: must be accepted at the very next edge
    sb.push_back('{R_GT, 4});
    start = 1'b1; a = 8'h13; b = 8'h12;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL b2b_accept: busy got %b want 1", busy);
    end
    wait_done(lat, res, to);
    e = sb.pop_front();
    n_cmp++;
    if (to || lat != e.lat || res !== e.res) begin
      n_bad++; $display("FAIL b2b_second: got lat %0d res %b want lat %0d res %b", lat, res, e.lat, e.res);
    end
  endtask

  task automatic test_busy_ignore();
    int lat; logic [2:0] res; bit to; exp_t e;
    sb.push_back('{R_EQ, 2});
    issue(8'hA5, 8'hA5);
    start = 1'b1; a = 8'h00; b = 8'hFF;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, res, to);
    e = sb.pop_front();
    n_cmp++;
    if (to || lat != e.lat) begin
      n_bad++; $display("FAIL ignore_latency: got %0d (timeout=%0b) want %0d", lat, to, e.lat);
    end
    n_cmp++;
    if (res !== e.res) begin
      n_bad++; $display("FAIL ignore_result: got %b want %b", res, e.res);
    end
  endtask

  task automatic test_reset_midrun();
    int lat; logic [2:0] res; bit to; int seen; exp_t e;
    issue(8'hA5, 8'hA5);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, eq, lt, gt} !== 5'b00000) begin
      n_bad++; $display("FAIL midrun_reset: got %b want 00000", {busy, done, eq, lt, gt});
    end
    seen = 0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++; $display("FAIL no_done_after_reset: got %0d pulses want 0", seen);
    end
    // Start asserted together with reset release: first edge accepts it
    sb.push_back('{R_GT, LAT_S3});
    @(negedge clk);
    rst = 1'b1;
    #1;
    start = 1'b1; a = 8'h80; b = 8'h7F;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL start_after_reset: busy got %b want 1", busy);
    end
    wait_done(lat, res, to);
    e = sb.pop_front();
    n_cmp++;
    if (to || lat != e.lat || res !== e.res) begin
      n_bad++; $display("FAIL post_reset_run: got lat %0d res %b want lat %0d res %b", lat, res, e.lat, e.res);
    end
  endtask

  initial begin
    test_reset();
    test_main();
    test_back_to_back();
    test_busy_ignore();
    test_reset_midrun();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_drain: %0d entries left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cmp_serial.md
CMP_SERIAL -- requirements
Module: cmp_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (even, >= 2).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request a comparison, sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  operand A, unsigned.
REQ-006 SHALL have port b  input  WIDTH  operand B, unsigned.
REQ-007 SHALL have port busy  output  1  high while a comparison is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-009 SHALL have port eq  output  1  registered result A == B.
REQ-010 SHALL have port lt  output  1  registered result A < B.
REQ-011 SHALL have port gt  output  1  registered result A > B.

Function
REQ-012 SHALL implement FSM states IDLE and RUN; busy = (state == RUN).
REQ-013 SHALL, on a rising edge in IDLE with start=1, latch a and b into internal registers, set slice index to WIDTH/2-1, clear eq/lt/gt to 0, and enter RUN.
REQ-014 SHALL ignore start and any changes on a/b while in RUN.
REQ-015 SHALL, each RUN cycle, compare one 2-bit slice {A[2i+1:2i], B[2i+1:2i]} MSB-slice first, using 2-bit equal/less/greater logic.
REQ-016 SHALL record the first differing slice as the result: gt=1 if A slice > B slice, else lt=1; later slices SHALL NOT change a recorded result.
REQ-017 SHALL, when all WIDTH/2 slices are equal, set eq=1.
REQ-018 SHALL, on the edge that finalises the result, register done=1 for exactly one cycle and return to IDLE.
REQ-019 SHALL make exactly one of eq/lt/gt high while done=1, and hold eq/lt/gt until the next accepted start.
REQ-020 SHALL accept a new start in the cycle done is high (back-to-back operation, no idle bubble).
REQ-021 SHALL latency: start accepted at edge E0; slice WIDTH/2-k evaluated at edge E0+k; full-length comparison has done high in the cycle after edge E0+WIDTH/2.
REQ-022 SHALL treat all-zero and all-one operands the same as any other equal operands (eq=1, full length).

Reset
REQ-023 SHALL, on rst=1 at any time including mid-RUN, immediately force state=IDLE, busy=0, done=0, eq=0, lt=0, gt=0, slice index=0, and clear the operand registers.
REQ-024 SHALL accept start on the first rising edge after rst deasserts.

Configuration
REQ-025 SHALL use macro CMP_EARLY_EXIT_EN.
REQ-026 SHALL, with CMP_EARLY_EXIT_EN defined, finalise at the edge evaluating the first differing slice (done at edge E0+k for slice index WIDTH/2-k), returning to IDLE early.
REQ-027 SHALL, without CMP_EARLY_EXIT_EN, always run all WIDTH/2 slices (constant latency, done at edge E0+WIDTH/2) with result frozen at first difference.

Verification (WIDTH=8)
REQ-028 SHALL cover: a=8'hA5, b=8'hA5, start pulse -> busy 4 cycles, done pulse at E0+4, eq=1, lt=gt=0.
REQ-029 SHALL cover: a=8'h80, b=8'h7F -> gt=1; done at E0+1 with CMP_EARLY_EXIT_EN, at E0+4 without.
REQ-030 SHALL cover: a=8'h12, b=8'h13 -> lt=1, done at E0+4 in both configurations; then a=8'h13, b=8'h12 back-to-back start in the done cycle -> gt=1.
REQ-031 SHALL cover: start=1 with new a/b while busy -> ignored, first result (from REQ-028 operands) reported unchanged.
REQ-032 SHALL cover: rst pulse at E0+2 of a run -> busy/done/eq/lt/gt all 0 asynchronously, no done pulse follows; next start completes normally.
